sudoku_io_sequencer: RTL and testbench

SUDOKU_IO_SEQUENCER -- requirements
Module: sudoku_io_sequencer

---
 rtl/sudoku_io_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_sudoku_io_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_io_sequencer.sv
// -----------------------------------------------------------------------------
// sudoku_io_sequencer
//
// Sequences a Sudoku board between a byte UART and a cell-addressed board
// memory. Incoming ASCII digits are written into the board one cell at a time.
// The solver is started once the board is full. After a solve, the board is
// read back and sent out as ASCII digits. If the solver fails, a single
// failure character is sent instead.
//
// Parameters
//   P_CELLS      number of board cells loaded and unloaded (<= 128)
//   P_FAIL_CHAR  byte transmitted when the solver reports failure
//
// Ports
//   i_Clk            clock; all state changes happen on its rising edge
//   i_Rst_L          asynchronous active-low reset
//   i_Rx_Completed   one-cycle pulse: i_Rx_Byte is valid
//   i_Rx_Byte        received ASCII byte
//   o_Cell_We        board write strobe
//   o_Cell_Addr      board cell index
//   o_Cell_Wdata     cell digit, 0 = empty
//   i_Cell_Rdata     board read data, valid one cycle after o_Cell_Addr
//   o_Solve_Start    one-cycle solver start pulse
//   i_Solve_Done     one-cycle pulse: solve succeeded
//   i_Solve_Fail     one-cycle pulse: board unsolvable
//   o_Tx_Byte        byte to transmit
//   o_Tx_Ready       level request to the UART TX
//   i_Tx_Completed   one-cycle pulse: UART TX finished the byte
//   o_Busy           low only while idle in LOAD with no cells received
//   o_Error          set by a failure report, cleared by the next cell-0 write
// -----------------------------------------------------------------------------
module sudoku_io_sequencer #(
  parameter int unsigned P_CELLS     = 81,
  parameter logic [7:0]  P_FAIL_CHAR = 8'h58
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Rx_Completed,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Cell_We,
  output logic [6:0] o_Cell_Addr,
  output logic [3:0] o_Cell_Wdata,
  input  logic [3:0] i_Cell_Rdata,
  output logic       o_Solve_Start,
  input  logic       i_Solve_Done,
  input  logic       i_Solve_Fail,
  output logic [7:0] o_Tx_Byte,
  output logic       o_Tx_Ready,
  input  logic       i_Tx_Completed,
  output logic       o_Busy,
  output logic       o_Error
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_START,
    S_SOLVE,
    S_READ,
    S_SEND,
    S_FAIL
  } t_state;

  localparam logic [6:0] C_LAST = 7'(P_CELLS - 1);

  t_state     r_State,       w_State;
  logic [6:0] r_Cnt,         w_Cnt;
  logic       r_Rd_Wait,     w_Rd_Wait;
  logic       r_Cell_We,     w_Cell_We;
  logic [6:0] r_Cell_Addr,   w_Cell_Addr;
  logic [3:0] r_Cell_Wdata,  w_Cell_Wdata;
  logic       r_Solve_Start, w_Solve_Start;
  logic [7:0] r_Tx_Byte,     w_Tx_Byte;
  logic       r_Tx_Ready,    w_Tx_Ready;
  logic       r_Error,       w_Error;
  logic       w_Is_Digit;

  assign w_Is_Digit = (i_Rx_Byte >= 8'h30) && (i_Rx_Byte <= 8'h39);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State       <= S_LOAD;
      r_Cnt         <= '0;
      r_Rd_Wait     <= 1'b0;
      r_Cell_We     <= 1'b0;
      r_Cell_Addr   <= '0;
      r_Cell_Wdata  <= '0;
      r_Solve_Start <= 1'b0;
      r_Tx_Byte     <= '0;
      r_Tx_Ready    <= 1'b0;
      r_Error       <= 1'b0;
    end else begin
      r_State       <= w_State;
      r_Cnt         <= w_Cnt;
      r_Rd_Wait     <= w_Rd_Wait;
      r_Cell_We     <= w_Cell_We;
      r_Cell_Addr   <= w_Cell_Addr;
      r_Cell_Wdata  <= w_Cell_Wdata;
      r_Solve_Start <= w_Solve_Start;
      r_Tx_Byte     <= w_Tx_Byte;
      r_Tx_Ready    <= w_Tx_Ready;
      r_Error       <= w_Error;
    end
  end

  always_comb begin
    w_State       = r_State;
    w_Cnt         = r_Cnt;
    w_Rd_Wait     = r_Rd_Wait;
    w_Cell_We     = 1'b0;
    w_Cell_Addr   = r_Cell_Addr;
    w_Cell_Wdata  = r_Cell_Wdata;
    w_Solve_Start = 1'b0;
    w_Tx_Byte     = r_Tx_Byte;
    w_Tx_Ready    = r_Tx_Ready;
    w_Error       = r_Error;

    case (r_State)
      S_LOAD: begin
        if (i_Rx_Completed && w_Is_Digit) begin
          w_Cell_We    = 1'b1;
          w_Cell_Addr  = r_Cnt;
          // For '0'..'9' the low nibble is already the digit value.
          w_Cell_Wdata = i_Rx_Byte[3:0];
          if (r_Cnt == '0) begin
            w_Error = 1'b0;
          end
          if (r_Cnt == C_LAST) begin
            w_Cnt   = '0;
            w_State = S_START;
          end else begin
            w_Cnt = r_Cnt + 7'd1;
          end
        end
      end

      S_START: begin
        w_Solve_Start = 1'b1;
        w_State       = S_SOLVE;
      end

      S_SOLVE: begin
        // A failure wins when both reports arrive in the same cycle.
        if (i_Solve_Fail) begin
          w_Error    = 1'b1;
          w_Tx_Byte  = P_FAIL_CHAR;
          w_Tx_Ready = 1'b1;
          w_State    = S_FAIL;
        end else if (i_Solve_Done) begin
          w_Cnt       = '0;
          w_Cell_Addr = '0;
          w_Rd_Wait   = 1'b0;
          w_State     = S_READ;
        end
      end

      S_READ: begin
        // First cycle presents the address, second captures the read data.
        if (!r_Rd_Wait) begin
          w_Rd_Wait = 1'b1;
        end else begin
          w_Rd_Wait  = 1'b0;
          w_Tx_Byte  = 8'h30 + {4'h0, i_Cell_Rdata};
          w_Tx_Ready = 1'b1;
          w_State    = S_SEND;
        end
      end

      S_SEND: begin
        if (i_Tx_Completed) begin
          w_Tx_Ready = 1'b0;
          if (r_Cnt < C_LAST) begin
            w_Cnt       = r_Cnt + 7'd1;
            w_Cell_Addr = r_Cnt + 7'd1;
            w_State     = S_READ;
          end else begin
            w_Cnt       = '0;
            w_Cell_Addr = '0;
            w_State     = S_LOAD;
          end
        end
      end

      S_FAIL: begin
        if (i_Tx_Completed) begin
          w_Tx_Ready  = 1'b0;
          w_Cnt       = '0;
          w_Cell_Addr = '0;
          w_State     = S_LOAD;
        end
      end

      default: begin
        w_State = S_LOAD;
      end
    endcase
  end

  assign o_Cell_We     = r_Cell_We;
  assign o_Cell_Addr   = r_Cell_Addr;
  assign o_Cell_Wdata  = r_Cell_Wdata;
  assign o_Solve_Start = r_Solve_Start;
  assign o_Tx_Byte     = r_Tx_Byte;
  assign o_Tx_Ready    = r_Tx_Ready;
  assign o_Error       = r_Error;
  assign o_Busy        = !((r_State == S_LOAD) && (r_Cnt == '0));

endmodule

// File: tb/tb_sudoku_io_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sudoku_io_sequencer
//
// Drives random Sudoku boards through the sequencer with junk bytes mixed in.
// Models the board memory and a solver that swaps in a random solution. Serves
// the TX handshake with random, and occasionally very long, completion delays.
// Every write and every transmitted byte is checked against the board arrays
// that the bench generated.
// -----------------------------------------------------------------------------
module tb_sudoku_io_sequencer;

  logic       i_Clk = 1'b0;
  logic       i_Rst_L;
  logic       i_Rx_Completed;
  logic [7:0] i_Rx_Byte;
  logic       o_Cell_We;
  logic [6:0] o_Cell_Addr;
  logic [3:0] o_Cell_Wdata;
  logic [3:0] i_Cell_Rdata;
  logic       o_Solve_Start;
  logic       i_Solve_Done;
  logic       i_Solve_Fail;
  logic [7:0] o_Tx_Byte;
  logic       o_Tx_Ready;
  logic       i_Tx_Completed;
  logic       o_Busy;
  logic       o_Error;

  always #5 i_Clk = ~i_Clk;

  sudoku_io_sequencer #(.P_CELLS(81), .P_FAIL_CHAR(8'h58)) dut (
    .i_Clk          (i_Clk),
    .i_Rst_L        (i_Rst_L),
    .i_Rx_Completed (i_Rx_Completed),
    .i_Rx_Byte      (i_Rx_Byte),
    .o_Cell_We      (o_Cell_We),
    .o_Cell_Addr    (o_Cell_Addr),
    .o_Cell_Wdata   (o_Cell_Wdata),
    .i_Cell_Rdata   (i_Cell_Rdata),
    .o_Solve_Start  (o_Solve_Start),
    .i_Solve_Done   (i_Solve_Done),
    .i_Solve_Fail   (i_Solve_Fail),
    .o_Tx_Byte      (o_Tx_Byte),
    .o_Tx_Ready     (o_Tx_Ready),
    .i_Tx_Completed (i_Tx_Completed),
    .o_Busy         (o_Busy),
    .o_Error        (o_Error)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] puzzle   [81];
  logic [3:0] solution [81];
  logic [3:0] tb_mem   [128];
  logic       use_solution = 1'b0;
  int         wr_addr_q[$];
  int         wr_data_q[$];
  int         ss_cnt = 0;

  // Board memory: written by the DUT, replaced by the solution once "solved".
  always @(posedge i_Clk)
    i_Cell_Rdata <= use_solution ? solution[o_Cell_Addr] : tb_mem[o_Cell_Addr];

  always @(negedge i_Clk) begin
    if (i_Rst_L === 1'b1) begin
      if (o_Cell_We) begin
        wr_addr_q.push_back(int'(o_Cell_Addr));
        wr_data_q.push_back(int'(o_Cell_Wdata));
        tb_mem[o_Cell_Addr] = o_Cell_Wdata;
      end
      if (o_Solve_Start) ss_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  function automatic logic [7:0] junk_byte();
    case ($urandom_range(0, 4))
      0: return 8'h0D;
      1: return 8'h0A;
      2: return 8'h20;
      3: return ($urandom_range(0, 1) == 0) ? 8'h2F : 8'h3A;
      default: return 8'($urandom_range(64, 255));
    endcase
  endfunction

  task automatic rx_byte(input logic [7:0] b);
    i_Rx_Byte      = b;
    i_Rx_Completed = 1'b1;
    @(negedge i_Clk);
    i_Rx_Completed = 1'b0;
    i_Rx_Byte      = 8'($urandom);
    idle($urandom_range(0, 2));
  endtask

  task automatic new_board();
    for (int i = 0; i < 81; i++) begin
      puzzle[i]   = 4'($urandom_range(0, 9));
      solution[i] = 4'($urandom_range(1, 9));
    end
    use_solution = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    ss_cnt = 0;
  endtask

  task automatic load_digits(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if ($urandom_range(0, 2) == 0) rx_byte(junk_byte());
      rx_byte({4'h3, puzzle[i]});
    end
  endtask

  task automatic check_writes(input int n);
    n_cmp++;
    if (wr_addr_q.size() != n) begin
      n_err++;
      $display("FAIL write_count: got %0d required %0d", wr_addr_q.size(), n);
    end
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      n_cmp++;
      if (wr_addr_q[i] != i || wr_data_q[i] != int'(puzzle[i])) begin
        n_err++;
        $display("FAIL write_%0d: got addr %0d data %0d required addr %0d data %0d",
                 i, wr_addr_q[i], wr_data_q[i], i, puzzle[i]);
      end
    end
  endtask

  // Serves n TX bytes; long mode holds completion 1000 cycles on some bytes.
  task automatic serve_tx(input int n, input bit is_fail, input int maxd,
                          input bit long_mode, input bit inject);
    for (int k = 0; k < n; k++) begin
      logic [7:0] b;
      logic [7:0] exp_b;
      bit         stable;
      int         w;
      int         delay;
      w = 0;
      while (!o_Tx_Ready && w < 20) begin
        @(negedge i_Clk);
        w++;
      end
      n_cmp++;
      if (!o_Tx_Ready) begin
        n_err++;
        $display("FAIL tx_wait_%0d: got tx_ready 0 required 1 within 20 cycles", k);
        return;
      end
      exp_b = is_fail ? 8'h58 : {4'h3, solution[k]};
      b = o_Tx_Byte;
      n_cmp++;
      if (b !== exp_b) begin
        n_err++;
        $display("FAIL tx_byte_%0d: got %02h required %02h", k, b, exp_b);
      end
      delay = (long_mode && (k < 2 || k == n - 1)) ? 1000 : $urandom_range(0, maxd);
      stable = 1'b1;
      repeat (delay) begin
        if (inject && $urandom_range(0, 3) == 0) begin
          i_Rx_Byte      = {4'h3, 4'($urandom_range(0, 9))};
          i_Rx_Completed = 1'b1;
        end
        @(negedge i_Clk);
        i_Rx_Completed = 1'b0;
        if (o_Tx_Byte !== b || o_Tx_Ready !== 1'b1) stable = 1'b0;
      end
      n_cmp++;
      if (!stable) begin
        n_err++;
        $display("FAIL tx_hold_%0d: got unstable byte/ready required stable %02h", k, b);
      end
      i_Tx_Completed = 1'b1;
      @(negedge i_Clk);
      i_Tx_Completed = 1'b0;
      n_cmp++;
      if (o_Tx_Ready !== 1'b0) begin
        n_err++;
        $display("FAIL tx_gap_%0d: got tx_ready %b required 0", k, o_Tx_Ready);
      end
    end
  endtask

  task automatic test_reset();
    i_Rst_L        = 1'b0;
    i_Rx_Byte      = 8'h35;
    i_Rx_Completed = 1'b1;
    i_Solve_Done   = 1'b1;
    i_Solve_Fail   = 1'b0;
    i_Tx_Completed = 1'b1;
    idle(4);
    n_cmp++;
    if ({o_Cell_We, o_Cell_Addr, o_Cell_Wdata, o_Solve_Start, o_Tx_Byte,
         o_Tx_Ready, o_Busy, o_Error} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got we%b addr%0d wd%0d ss%b tx%02h rdy%b busy%b err%b required all 0",
               o_Cell_We, o_Cell_Addr, o_Cell_Wdata, o_Solve_Start, o_Tx_Byte,
               o_Tx_Ready, o_Busy, o_Error);
    end
    i_Rst_L        = 1'b1;
    i_Rx_Completed = 1'b0;
    i_Solve_Done   = 1'b0;
    i_Tx_Completed = 1'b0;
    idle(3);
    n_cmp++;
    if (wr_addr_q.size() != 0 || o_Busy !== 1'b0 || ss_cnt != 0) begin
      n_err++;
      $display("FAIL reset_release: got writes %0d busy %b starts %0d required 0 0 0",
               wr_addr_q.size(), o_Busy, ss_cnt);
    end
  endtask

  task automatic test_load();
    new_board();
    load_digits(0, 79);
    i_Rx_Byte      = {4'h3, puzzle[80]};
    i_Rx_Completed = 1'b1;
    @(negedge i_Clk);
    i_Rx_Completed = 1'b0;
    n_cmp++;
    if (o_Cell_We !== 1'b1 || o_Cell_Addr !== 7'd80 || o_Solve_Start !== 1'b0) begin
      n_err++;
      $display("FAIL last_write: got we %b addr %0d start %b required 1 80 0",
               o_Cell_We, o_Cell_Addr, o_Solve_Start);
    end
    @(negedge i_Clk);
    n_cmp++;
    if (o_Solve_Start !== 1'b1) begin
      n_err++;
      $display("FAIL start_latency: got start %b required 1 two cycles after last digit", o_Solve_Start);
    end
    idle(2);
    check_writes(81);
    n_cmp++;
    if (ss_cnt != 1 || o_Busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_count: got starts %0d busy %b required 1 1", ss_cnt, o_Busy);
    end
  endtask

  task automatic test_solve(input int maxd, input bit long_mode, input bit inject);
    int lat;
    if (inject) begin
      for (int i = 0; i < 3; i++) rx_byte({4'h3, 4'($urandom_range(0, 9))});
    end
    use_solution   = 1'b1;
    i_Solve_Done   = 1'b1;
    @(negedge i_Clk);
    i_Solve_Done   = 1'b0;
    lat = 1;
    while (!o_Tx_Ready && lat < 10) begin
      @(negedge i_Clk);
      lat++;
    end
    n_cmp++;
    if (lat > 3) begin
      n_err++;
      $display("FAIL done_latency: got %0d cycles required <= 3", lat);
    end
    serve_tx(81, 1'b0, maxd, long_mode, inject);
    idle(3);
    n_cmp++;
    if (o_Busy !== 1'b0 || o_Tx_Ready !== 1'b0 || wr_addr_q.size() != 81 || ss_cnt != 1) begin
      n_err++;
      $display("FAIL solve_end: got busy %b ready %b writes %0d starts %0d required 0 0 81 1",
               o_Busy, o_Tx_Ready, wr_addr_q.size(), ss_cnt);
    end
  endtask

  task automatic test_fail();
    new_board();
    load_digits(0, 80);
    idle(3);
    i_Solve_Done = 1'b1;
    i_Solve_Fail = 1'b1;
    @(negedge i_Clk);
    i_Solve_Done = 1'b0;
    i_Solve_Fail = 1'b0;
    n_cmp++;
    if (o_Error !== 1'b1) begin
      n_err++;
      $display("FAIL fail_error: got %b required 1", o_Error);
    end
    serve_tx(1, 1'b1, 4, 1'b0, 1'b1);
    idle(5);
    n_cmp++;
    if (o_Tx_Ready !== 1'b0 || o_Busy !== 1'b0 || o_Error !== 1'b1 || wr_addr_q.size() != 81) begin
      n_err++;
      $display("FAIL fail_end: got ready %b busy %b err %b writes %0d required 0 0 1 81",
               o_Tx_Ready, o_Busy, o_Error, wr_addr_q.size());
    end
    new_board();
    rx_byte({4'h3, puzzle[0]});
    n_cmp++;
    if (o_Error !== 1'b0 || wr_addr_q.size() != 1 || o_Busy !== 1'b1) begin
      n_err++;
      $display("FAIL error_clear: got err %b writes %0d busy %b required 0 1 1",
               o_Error, wr_addr_q.size(), o_Busy);
    end
  endtask

  task automatic test_reset_midload();
    load_digits(1, 39);
    check_writes(40);
    #2;
    i_Rst_L = 1'b0;
    #1;
    n_cmp++;
    if ({o_Cell_We, o_Cell_Addr, o_Cell_Wdata, o_Solve_Start, o_Tx_Byte,
         o_Tx_Ready, o_Busy, o_Error} !== '0) begin
      n_err++;
      $display("FAIL midload_reset: got addr %0d wd %0d busy %b required all 0",
               o_Cell_Addr, o_Cell_Wdata, o_Busy);
    end
    @(negedge i_Clk);
    i_Rst_L = 1'b1;
    idle(2);
    test_load();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) tb_mem[i] = 4'h0;
    i_Rx_Byte = 8'h00;
    i_Rx_Completed = 1'b0;
    i_Solve_Done = 1'b0;
    i_Solve_Fail = 1'b0;
    i_Tx_Completed = 1'b0;
    test_reset();
    test_load();
    test_solve(3, 1'b0, 1'b1);
    test_load();
    test_solve(0, 1'b0, 1'b0);
    test_fail();
    test_reset_midload();
    test_solve(2, 1'b1, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
